// File: rtl/instr_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : instr_issue_queue
// Purpose  : Instruction FIFO between the fetch unit and a multi-cycle core.
//            Entries are issued one at a time with a one-cycle run_core pulse.
//            The next entry is issued only after core_done. A synchronous
//            flush discards every queued entry. The instruction already
//            issued to the core is not aborted by a flush.
// Ports    : clk                        rising-edge clock
//            reset                      asynchronous, active-low reset
//            flush                      drop all queued entries (sync)
//            in_valid/in_instr/in_pc    fetch side; in_ready = !full
//            core_done                  core finished the issued instruction
//            run_core                   one-cycle issue pulse (state == ISSUE)
//            instr/issue_pc             last issued instruction and its PC
//            count/empty/full           occupancy, from registered state only
// Revision : 1.0 - initial release
// ============================================================================
module instr_issue_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [15:0]              in_instr,
  input  logic [PC_W-1:0]          in_pc,
  output logic                     in_ready,
  input  logic                     core_done,
  output logic                     run_core,
  output logic [15:0]              instr,
  output logic [PC_W-1:0]          issue_pc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [AW:0]     count_q;
  logic [15:0]     instr_q;
  logic [PC_W-1:0] issue_pc_q;
  logic [15:0]     instr_mem_q [DEPTH];
  logic [PC_W-1:0] pc_mem_q    [DEPTH];

  logic            do_push;
  logic            do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  assign in_ready = !full;
  assign count    = count_q;
  assign instr    = instr_q;
  assign issue_pc = issue_pc_q;

  // Flush wins over push, so a word offered during flush is dropped.
  assign do_push = in_valid && !full && !flush;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and pop decision. The pop happens on the edge that
  // enters ISSUE. A flush suppresses the pop. The current instruction is
  // still allowed to complete, so ISSUE falls into WAIT and then IDLE. A
  // core_done seen during ISSUE completes the instruction even when a flush
  // arrives on the same edge.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    do_pop  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty && !flush) begin
          do_pop  = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE, S_WAIT: begin
        if (core_done) begin
          if (!empty && !flush) begin
            do_pop  = 1'b1;
            state_d = S_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    run_core = (state_q == S_ISSUE);
  end

  // --------------------------------------------------------------------------
  // Storage: no reset needed. An entry is only read after it has been written.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (do_push) begin
      instr_mem_q[wr_ptr_q] <= in_instr;
      pc_mem_q[wr_ptr_q]    <= in_pc;
    end
  end

  // --------------------------------------------------------------------------
  // Pointers, occupancy and issued-instruction registers. Pointers wrap
  // naturally because DEPTH is a power of two.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      instr_q    <= 16'h0000;
      issue_pc_q <= '0;
    end else begin
      if (do_pop) begin
        instr_q    <= instr_mem_q[rd_ptr_q];
        issue_pc_q <= pc_mem_q[rd_ptr_q];
      end
      if (flush) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_issue_queue
// Purpose  : Self-checking bench for instr_issue_queue. The reference model
//            holds a queue of pending words and a "core busy" flag. Each
//            issued word goes to a scoreboard. A separate monitor pops the
//            scoreboard on every run_core pulse and compares instr and
//            issue_pc.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_issue_queue;
  localparam int DEPTH = 4;
  localparam int PC_W  = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic [15:0]     in_instr = '0;
  logic [PC_W-1:0] in_pc = '0;
  logic            core_done = 1'b0;
  logic            in_ready, run_core, empty, full;
  logic [15:0]     instr;
  logic [PC_W-1:0] issue_pc;
  logic [$clog2(DEPTH):0] count;

  instr_issue_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_instr(in_instr), .in_pc(in_pc), .in_ready(in_ready),
    .core_done(core_done), .run_core(run_core), .instr(instr),
    .issue_pc(issue_pc), .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [15:0] ins; logic [PC_W-1:0] pc; } item_t;

  item_t mq[$];      // words waiting in the queue
  item_t exp_q[$];   // issued words the monitor has still to see
  item_t mon_last;
  bit    busy = 1'b0;
  bit    iss_last = 1'b0;
  int    checks = 0;
  int    failures = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference behaviour for one rising edge, from the queue's rules.
  task automatic model_edge();
    int  pre_size;
    bit  completing;
    item_t it;
    pre_size   = mq.size();
    completing = busy && core_done;
    iss_last   = (!busy || completing) && pre_size > 0 && !flush;
    if (iss_last) begin
      it = mq.pop_front();
      exp_q.push_back(it);
      busy = 1'b1;
    end else if (completing) begin
      busy = 1'b0;
    end
    if (flush) mq.delete();
    else if (in_valid && pre_size < DEPTH) mq.push_back({in_instr, in_pc});
  endtask

  // Called at a falling edge: drive, clock once, check occupancy at the next fall.
  task automatic step(input bit v, input logic [15:0] ins, input logic [PC_W-1:0] pc,
                      input bit done, input bit fl);
    in_valid = v; in_instr = ins; in_pc = pc; core_done = done; flush = fl;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("count", count, mq.size());
    chk("empty", empty, mq.size() == 0);
    chk("full", full, mq.size() == DEPTH);
    chk("in_ready", in_ready, mq.size() != DEPTH);
    chk("run_core", run_core, iss_last);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (busy || mq.size() != 0); i++) step(0, 0, 0, i % 2, 0);
    chk("drain_done", busy || mq.size() != 0, 0);
  endtask

  // Monitor: compares every issue against the scoreboard, and checks that
  // instr/issue_pc hold their value between issues.
  initial begin
    mon_last = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        mon_last = '0;
      end else if (run_core) begin
        if (exp_q.size() == 0) begin
          chk("spurious_run_core", 1, 0);
        end else begin
          mon_last = exp_q.pop_front();
          chk("issue_instr", instr, mon_last.ins);
          chk("issue_pc", issue_pc, mon_last.pc);
        end
      end else begin
        chk("hold_instr", instr, mon_last.ins);
        chk("hold_pc", issue_pc, mon_last.pc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values
    #12;
    chk("rst_run_core", run_core, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_instr", instr, 16'h0000);
    @(negedge clk);
    reset = 1'b1;

    // Single issue
    step(1, 16'h1234, 16'h0000, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("single_pulse", run_core, 1);
    step(0, 0, 0, 0, 0);
    chk("single_instr", instr, 16'h1234);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("single_empty", empty, 1);

    // Fill with the core stalled; the sixth word must be refused
    for (int i = 0; i < 6; i++) step(1, 16'hA000 + 16'(i), 16'(16 * i), 0, 0);
    chk("fill_count", count, 4);
    chk("fill_full", full, 1);
    chk("fill_in_ready", in_ready, 0);
    drain();

    // Back-to-back: three words queued behind a busy core
    step(1, 16'hB000, 16'h0100, 0, 0);
    step(1, 16'hB00A, 16'h0104, 0, 0);
    step(1, 16'hB00B, 16'h0108, 0, 0);
    step(1, 16'hB00C, 16'h010C, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 0);
      chk("b2b_pulse", run_core, 1);
    end
    step(0, 0, 0, 1, 0);
    chk("b2b_idle", run_core, 0);

    // Flush while waiting: queued words and the concurrent push are dropped
    step(1, 16'hC000, 16'h0200, 0, 0);
    step(1, 16'hC001, 16'h0204, 0, 0);
    step(1, 16'hC002, 16'h0208, 0, 0);
    step(1, 16'hC003, 16'h020C, 0, 1);
    chk("flush_count", count, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    chk("flush_empty", empty, 1);

    // Randomised traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 1), 16'($urandom), 16'($urandom),
           $urandom_range(0, 2) == 0, $urandom_range(0, 29) == 0);
    drain();

    // Asynchronous reset in the middle of WAIT
    step(1, 16'hD000, 16'h0300, 0, 0);
    step(1, 16'hD001, 16'h0304, 0, 0);
    step(1, 16'hD002, 16'h0308, 0, 0);
    #2 reset = 1'b0;
    #1;
    chk("arst_run_core", run_core, 0);
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_instr", instr, 16'h0000);
    chk("arst_pc", issue_pc, 0);
    mq.delete(); exp_q.delete(); busy = 1'b0; iss_last = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
    step(1, 16'hE000, 16'h0400, 0, 0);
    drain();
    @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
